// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory among NUM_CORES cores.
// Optional atomic bus lock enabled by defining DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_CORES-1:0]          i_req,
    input  logic [NUM_CORES-1:0]          i_we,
    input  logic [NUM_CORES*ADDR_W-1:0]   i_addr,
    input  logic [NUM_CORES*DATA_W-1:0]   i_wdata,
    input  logic [NUM_CORES-1:0]          i_lock,
    output logic [NUM_CORES-1:0]          o_gnt,
    output logic [NUM_CORES-1:0]          o_done,
    output logic [DATA_W-1:0]             o_rdata,
    output logic [ADDR_W-1:0]             o_mem_addr,
    output logic [DATA_W-1:0]             o_mem_wdata,
    output logic                          o_mem_we,
    output logic                          o_mem_re,
    input  logic [DATA_W-1:0]             i_mem_rdata
);

    localparam int unsigned PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int unsigned CNT_W = 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            r_state,     w_state_nxt;
    logic [PTR_W-1:0]      r_ptr,       w_ptr_nxt;
    logic [PTR_W-1:0]      r_owner,     w_owner_nxt;
    logic                  r_we,        w_we_nxt;
    logic [CNT_W-1:0]      r_cnt,       w_cnt_nxt;
    logic [NUM_CORES-1:0]  r_gnt,       w_gnt_nxt;
    logic [NUM_CORES-1:0]  r_done,      w_done_nxt;
    logic [DATA_W-1:0]     r_rdata,     w_rdata_nxt;
    logic [ADDR_W-1:0]     r_mem_addr,  w_mem_addr_nxt;
    logic [DATA_W-1:0]     r_mem_wdata, w_mem_wdata_nxt;
    logic                  r_mem_we,    w_mem_we_nxt;
    logic                  r_mem_re,    w_mem_re_nxt;

    logic                  w_found;
    logic [PTR_W-1:0]      w_sel;
    logic [PTR_W-1:0]      w_ptr_adv;
    logic                  w_lock_hold;

`ifdef DMEM_ARB_LOCK_EN
    assign w_lock_hold = i_lock[r_owner] & i_req[r_owner];
`else
    logic w_unused_lock;
    assign w_unused_lock = ^i_lock;
    assign w_lock_hold   = 1'b0;
`endif

    // First requester at or after r_ptr, wrapping; reverse scan lets the nearest one win.
    always_comb begin
        int j;
        j       = 0;
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = int'(NUM_CORES) - 1; k >= 0; k--) begin
            j = int'(r_ptr) + k;
            if (j >= int'(NUM_CORES)) begin
                j = j - int'(NUM_CORES);
            end
            if (i_req[j]) begin
                w_found = 1'b1;
                w_sel   = PTR_W'(j);
            end
        end
    end

    assign w_ptr_adv = (r_owner == PTR_W'(NUM_CORES - 1)) ? '0 : r_owner + PTR_W'(1);

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_owner_nxt     = r_owner;
        w_we_nxt        = r_we;
        w_cnt_nxt       = r_cnt;
        w_gnt_nxt       = r_gnt;
        w_done_nxt      = '0;
        w_rdata_nxt     = r_rdata;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_we_nxt    = 1'b0;
        w_mem_re_nxt    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_owner_nxt      = w_sel;
                    w_we_nxt         = i_we[w_sel];
                    w_mem_addr_nxt   = i_addr[int'(w_sel)*ADDR_W +: ADDR_W];
                    w_mem_wdata_nxt  = i_wdata[int'(w_sel)*DATA_W +: DATA_W];
                    w_mem_we_nxt     = i_we[w_sel];
                    w_mem_re_nxt     = ~i_we[w_sel];
                    w_gnt_nxt        = '0;
                    w_gnt_nxt[w_sel] = 1'b1;
                    w_state_nxt      = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (r_we) begin
                    w_done_nxt[r_owner] = 1'b1;
                    w_state_nxt         = S_DONE;
                end else begin
                    w_cnt_nxt   = CNT_W'(RD_LAT - 1);
                    w_state_nxt = S_WAIT;
                end
            end

            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_rdata_nxt         = i_mem_rdata;
                    w_done_nxt[r_owner] = 1'b1;
                    w_state_nxt         = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end

            S_DONE: begin
                // A locked owner chains straight into its next access, keeping the grant.
                if (w_lock_hold) begin
                    w_we_nxt        = i_we[r_owner];
                    w_mem_addr_nxt  = i_addr[int'(r_owner)*ADDR_W +: ADDR_W];
                    w_mem_wdata_nxt = i_wdata[int'(r_owner)*DATA_W +: DATA_W];
                    w_mem_we_nxt    = i_we[r_owner];
                    w_mem_re_nxt    = ~i_we[r_owner];
                    w_state_nxt     = S_ISSUE;
                end else begin
                    w_gnt_nxt   = '0;
                    w_ptr_nxt   = w_ptr_adv;
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_we        <= 1'b0;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_rdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_we        <= w_we_nxt;
            r_cnt       <= w_cnt_nxt;
            r_gnt       <= w_gnt_nxt;
            r_done      <= w_done_nxt;
            r_rdata     <= w_rdata_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_re    <= w_mem_re_nxt;
        end
    end

    assign o_gnt       = r_gnt;
    assign o_done      = r_done;
    assign o_rdata     = r_rdata;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_we    = r_mem_we;
    assign o_mem_re    = r_mem_re;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: scoreboard of expected transactions in grant order.
module tb_dmem_arbiter;

    localparam int unsigned NC = 4;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;

    typedef struct {
        int          core;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } txn_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NC-1:0]     req, we, lock;
    logic [NC*AW-1:0]  addr;
    logic [NC*DW-1:0]  wdata;
    logic [NC-1:0]     o_gnt, o_done;
    logic [DW-1:0]     o_rdata, o_mem_wdata, mem_rdata;
    logic [AW-1:0]     o_mem_addr;
    logic              o_mem_we, o_mem_re;

    logic [7:0] mem     [0:255];
    logic [7:0] ref_mem [0:255];
    logic       rv;
    logic [7:0] ra;
    txn_t       sb_q [$];
    int         checks   = 0;
    int         failures = 0;

    dmem_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr),
        .i_wdata(wdata), .i_lock(lock), .o_gnt(o_gnt), .o_done(o_done),
        .o_rdata(o_rdata), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .o_mem_we(o_mem_we), .o_mem_re(o_mem_re), .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: data valid only in the cycle after mem_re, junk otherwise.
    always @(posedge clk) begin
        rv <= o_mem_re;
        ra <= o_mem_addr[7:0];
        if (o_mem_we) mem[o_mem_addr[7:0]] <= o_mem_wdata;
    end
    assign mem_rdata = rv ? mem[ra] : 8'hEE;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int c, input logic w, input logic [15:0] a, input logic [7:0] d);
        req[c] = 1'b1;
        we[c]  = w;
        addr[c*AW +: AW]  = a;
        wdata[c*DW +: DW] = d;
    endtask

    task automatic push(input int c, input logic w, input logic [15:0] a, input logic [7:0] d);
        txn_t t;
        t.core = c;
        t.we   = w;
        t.addr = a;
        if (w) begin
            t.data = d;
            ref_mem[a[7:0]] = d;
        end else begin
            t.data = ref_mem[a[7:0]];
        end
        sb_q.push_back(t);
    endtask

    task automatic issue(input int c, input logic w, input logic [15:0] a, input logic [7:0] d);
        set_req(c, w, a, d);
        push(c, w, a, d);
    endtask

    task automatic wait_done(input int c, input bit drop);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (o_done[c]) seen = 1'b1;
        end
        chk($sformatf("done_seen_core%0d", c), 32'(seen), 32'd1);
        if (drop) req[c] = 1'b0;
    endtask

    // Scoreboard monitor: strobes must match the head entry, done pops it.
    always @(negedge clk) begin
        if (o_mem_we || o_mem_re) begin
            chk("strobe_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                chk("strobe_kind", 32'(o_mem_we), 32'(sb_q[0].we));
                chk("strobe_gnt", 32'(o_gnt), 32'd1 << sb_q[0].core);
                chk("strobe_addr", 32'(o_mem_addr), 32'(sb_q[0].addr));
                if (sb_q[0].we) chk("strobe_wdata", 32'(o_mem_wdata), 32'(sb_q[0].data));
            end
        end
        if (o_done != '0) begin
            chk("done_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                txn_t t;
                t = sb_q.pop_front();
                chk("done_onehot", 32'(o_done), 32'd1 << t.core);
                if (!t.we) chk("rdata", 32'(o_rdata), 32'(t.data));
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i) ^ 8'hC3;
            ref_mem[i] = 8'(i) ^ 8'hC3;
        end
        mem[32] = 8'h3C;
        ref_mem[32] = 8'h3C;
        rst = 1'b1; req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_gnt", 32'(o_gnt), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_rdata", 32'(o_rdata), 32'd0);
        chk("rst_mem_addr", 32'(o_mem_addr), 32'd0);
        chk("rst_strobes", 32'({o_mem_we, o_mem_re}), 32'd0);

        // Single write, core 0.
        issue(0, 1'b1, 16'h0010, 8'hA5);
        @(negedge clk);
        chk("wr_gnt", 32'(o_gnt), 32'h1);
        chk("wr_mem_we", 32'(o_mem_we), 32'd1);
        chk("wr_mem_addr", 32'(o_mem_addr), 32'h0010);
        chk("wr_mem_wdata", 32'(o_mem_wdata), 32'hA5);
        @(negedge clk);
        chk("wr_done", 32'(o_done), 32'h1);
        chk("wr_we_one_cycle", 32'(o_mem_we), 32'd0);
        req[0] = 1'b0;
        @(negedge clk);
        chk("wr_idle_gnt", 32'(o_gnt), 32'd0);

        // Single read, core 2, latency 3.
        issue(2, 1'b0, 16'h0020, 8'h00);
        @(negedge clk);
        chk("rd_gnt", 32'(o_gnt), 32'h4);
        chk("rd_mem_re", 32'(o_mem_re), 32'd1);
        @(negedge clk);
        chk("rd_wait_re", 32'(o_mem_re), 32'd0);
        chk("rd_wait_done", 32'(o_done), 32'd0);
        @(negedge clk);
        chk("rd_done", 32'(o_done), 32'h4);
        chk("rd_data", 32'(o_rdata), 32'h3C);
        req[2] = 1'b0;
        @(negedge clk);
        chk("rd_idle_gnt", 32'(o_gnt), 32'd0);
        chk("rd_hold", 32'(o_rdata), 32'h3C);

        // Contention from ptr=0: order 0,1,2,3, one bubble after each.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) issue(c, 1'b0, 16'(16'h0030 + c), 8'h00);
        for (int c = 0; c < 4; c++) begin
            wait_done(c, 1'b1);
            @(negedge clk);
            chk("cont_bubble", 32'(o_gnt), 32'd0);
        end
        issue(1, 1'b0, 16'h0041, 8'h00);
        issue(3, 1'b0, 16'h0043, 8'h00);
        wait_done(1, 1'b1);
        @(negedge clk);
        chk("rr_bubble", 32'(o_gnt), 32'd0);
        wait_done(3, 1'b1);
        @(negedge clk);

        // Requester drops req during ISSUE; transaction still completes.
        issue(1, 1'b0, 16'h0051, 8'h00);
        @(negedge clk);
        chk("drop_gnt", 32'(o_gnt), 32'h2);
        req[1] = 1'b0;
        wait_done(1, 1'b1);
        @(negedge clk);

        // Reset during WAIT: no done, outputs cleared, ptr back to 0.
        issue(2, 1'b0, 16'h0062, 8'h00);
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_wait_gnt", 32'(o_gnt), 32'h4);
        rst = 1'b1;
        req[2] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        void'(sb_q.pop_front());
        chk("abort_gnt", 32'(o_gnt), 32'd0);
        chk("abort_done", 32'(o_done), 32'd0);
        chk("abort_rdata", 32'(o_rdata), 32'd0);
        chk("abort_mem_addr", 32'(o_mem_addr), 32'd0);
        chk("abort_strobes", 32'({o_mem_we, o_mem_re}), 32'd0);
        @(negedge clk);
        chk("abort_no_done", 32'(o_done), 32'd0);
        issue(1, 1'b0, 16'h0071, 8'h00);
        issue(3, 1'b0, 16'h0073, 8'h00);
        wait_done(1, 1'b1);
        @(negedge clk);
        wait_done(3, 1'b1);
        @(negedge clk);

        // Lock: core 1 read then write to 0x0005 while core 0 waits.
        lock[1] = 1'b1;
        issue(1, 1'b0, 16'h0005, 8'h00);
        @(negedge clk);
        set_req(0, 1'b1, 16'h0040, 8'h77);
`ifndef DMEM_ARB_LOCK_EN
        push(0, 1'b1, 16'h0040, 8'h77);
`endif
        wait_done(1, 1'b0);
        set_req(1, 1'b1, 16'h0005, 8'h99);
        push(1, 1'b1, 16'h0005, 8'h99);
`ifdef DMEM_ARB_LOCK_EN
        push(0, 1'b1, 16'h0040, 8'h77);
        @(negedge clk);
        chk("lock_gnt_continuous", 32'(o_gnt), 32'h2);
        chk("lock_mem_we", 32'(o_mem_we), 32'd1);
        lock[1] = 1'b0;
        wait_done(1, 1'b1);
        @(negedge clk);
        chk("lock_release_bubble", 32'(o_gnt), 32'd0);
        wait_done(0, 1'b1);
`else
        @(negedge clk);
        chk("nolock_bubble", 32'(o_gnt), 32'd0);
        wait_done(0, 1'b1);
        lock[1] = 1'b0;
        wait_done(1, 1'b1);
`endif
        @(negedge clk);

        // Read back the locked write.
        issue(2, 1'b0, 16'h0005, 8'h00);
        wait_done(2, 1'b1);
        @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between NUM_CORES matrix-multiply cores.
- Each core's control unit raises a request for one memory read or write; dmem_arbiter grants one core at a time in round-robin order.
- Sequences the memory strobes, returns read data and pulses completion.
- Sits between the per-core AR/DR paths and the data memory.

Parameters:
NUM_CORES, 4, number of requesting cores (2..8)
ADDR_W, 16, memory address width
DATA_W, 8, memory data width
RD_LAT, 1, memory read latency in cycles, from the mem_re cycle to valid mem_rdata (1..4)

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  synchronous reset, active high
req  in  NUM_CORES  per-core access request, level
we  in  NUM_CORES  per-core: 1 = write, 0 = read; valid while req is high
addr  in  NUM_CORES*ADDR_W  per-core address, core i at [i*ADDR_W +: ADDR_W]
wdata  in  NUM_CORES*DATA_W  per-core write data, same packing
lock  in  NUM_CORES  per-core bus-lock request (used only with DMEM_ARB_LOCK_EN)
gnt  out  NUM_CORES  one-hot grant, held for the whole transaction
done  out  NUM_CORES  one-hot, one-cycle completion pulse
rdata  out  DATA_W  registered read data, broadcast to all cores
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_we  out  1  memory write strobe
mem_re  out  1  memory read strobe
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer ptr = 0.
- Rst aborts any transaction: no done pulse, memory strobes drop in the next cycle.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Selects the first i with req[i] = 1, searching from ptr upward and wrapping modulo NUM_CORES.
  - Latches owner = i, and latches that core's we, addr and wdata.
  - Sets gnt[i] and goes to ISSUE.
  - With no request, stays in IDLE.
- ISSUE (1 cycle):
  - mem_addr and mem_wdata come from the latched values.
  - Write: mem_we = 1, go to DONE.
  - Read: mem_re = 1, go to WAIT.
- WAIT (RD_LAT cycles, counted by a down-counter): on the final WAIT cycle, rdata <= mem_rdata, then go to DONE.
- DONE (1 cycle):
  - done[owner] = 1; rdata is valid in this cycle and holds until the next read capture.
  - ptr <= (owner+1) mod NUM_CORES; gnt cleared on exit; next state IDLE.
- Latency from the request being sampled in IDLE to the done pulse: write 2 cycles; read 2+RD_LAT cycles.
- Each transaction is followed by at least one IDLE bubble (except under lock, see below).
- Outputs mem_addr, mem_wdata, gnt and done are registered; mem_we and mem_re are asserted only in ISSUE.
- Request inputs are latched in IDLE:
  - Changes to a granted core's req, we, addr or wdata after that cycle have no effect.
  - Dropping req mid-transaction does not cancel it; done still pulses.
- Cores deassert req in the cycle after done. A req still high in the following IDLE is treated as a new request.
- Simultaneous requests are resolved by ptr only; no core waits more than NUM_CORES-1 transactions.

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- Defined:
  - If lock[owner] = 1 and req[owner] = 1 during DONE, the FSM goes directly from DONE to ISSUE for the same owner with no bubble.
  - It re-latches we, addr and wdata in DONE; gnt stays high and ptr is not advanced.
  - This gives atomic read-modify-write. Releasing lock returns to normal round-robin after the current transaction.
- Undefined: the lock port is present but ignored; behaviour is as described above.

Test Plan:
- Single write: Rst pulse, then core 0 req with we=1, addr=0x0010, wdata=0xA5 → gnt[0] next cycle, mem_we=1 with mem_addr=0x0010 and mem_wdata=0xA5 for exactly one cycle, done[0] two cycles after the request is sampled.
- Single read, RD_LAT=1: memory model returns 0x3C for address 0x0020; core 2 reads 0x0020 → mem_re for one cycle, rdata=0x3C and done[2] three cycles after the request.
- Contention: all four cores request reads with ptr=0 → grant order 0,1,2,3, each done followed by one IDLE cycle; the next round with cores 1 and 3 requesting after owner 3 → order 1, then 3.
- Requester drop: core 1 drops req in the ISSUE cycle → the transaction completes and done[1] still pulses.
- Reset mid-read: assert Rst in WAIT → no done pulse; all outputs 0 the next cycle; ptr=0.
- With DMEM_ARB_LOCK_EN: core 1 holds lock and does a read then a write to 0x0005 → no IDLE cycle between the two transactions, core 0's request is held off until lock drops, gnt[1] continuous.
